// File: rtl/gpr_dump_reader.sv
// Sweeps a register-file read port over x1..xN-1 and streams each value on a valid/ready link.
// Optional trailing XOR checksum word when GPR_DUMP_CHECKSUM_EN is defined.
module gpr_dump_reader #(
    parameter int RV32E      = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4:0]            raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [4:0]            dump_addr_o,
    output logic [DATA_WIDTH-1:0] dump_data_o,
    output logic                  dump_last_o
);

    localparam int         NUM_WORDS = (RV32E != 0) ? 16 : 32;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [4:0]            r_idx;
    logic [4:0]            r_raddr;
    logic [4:0]            r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;
    logic                  r_last;
    logic                  w_hs;
`ifdef GPR_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    assign w_hs = r_valid && dump_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_raddr <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_raddr <= '0;
                    if (start_i && !abort_i) begin
                        r_idx   <= 5'd1;
                        r_raddr <= 5'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
`ifdef GPR_DUMP_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    r_data  <= rdata_i;
                    r_addr  <= r_idx;
                    r_valid <= 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
                    r_last  <= 1'b0;
`else
                    r_last  <= (r_idx == LAST_IDX);
`endif
                    r_raddr <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
`ifdef GPR_DUMP_CHECKSUM_EN
                        r_csum <= r_csum ^ r_data;
`endif
                        if (r_idx == LAST_IDX) begin
`ifdef GPR_DUMP_CHECKSUM_EN
                            // Checksum word reuses the output registers; valid stays high.
                            r_addr  <= '0;
                            r_data  <= r_csum ^ r_data;
                            r_last  <= 1'b1;
                            r_state <= S_CSUM;
`else
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_raddr <= r_idx + 5'd1;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_LOAD;
                        end
                    end
                end
`ifdef GPR_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // Abort overrides everything above; a handshake in this cycle still counted.
            if (abort_i && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b0;
                r_busy  <= 1'b0;
                r_raddr <= '0;
            end
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign raddr_o      = r_raddr;
    assign dump_valid_o = r_valid;
    assign dump_addr_o  = r_addr;
    assign dump_data_o  = r_data;
    assign dump_last_o  = r_last;

endmodule
